lookahead_sub_pipe: RTL and testbench

- Two-stage pipelined n-bit subtractor with valid/ready handshakes on both sides.
- Computes `minuend - subtrahend - borrow_in` using the team's carry-lookahead generate/propagate structure on the two's-complement form `minuend + ~subtrahend + ~borrow_in`.
- It is the inverse-direction companion of `look_ahead_adder_n_bit`: the accelerator datapath uses it for difference and compare operations, between the operand fetch stage and the result writeback stage.

---
 rtl/lookahead_sub_pipe.sv | 118 +++++++++++
 tb/tb_lookahead_sub_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lookahead_sub_pipe.sv
// Two-stage pipelined subtractor: A - B - bin as A + ~B + ~bin with a lookahead carry per half.
// Define LA_SUB_OVF_EN to add a registered signed-overflow output.
module lookahead_sub_pipe #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] minuend,
  input  logic [SIZE-1:0] subtrahend,
  input  logic            borrow_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] diff,
  output logic            borrow_out
`ifdef LA_SUB_OVF_EN
  ,
  output logic            overflow
`endif
);

  localparam int H = SIZE / 2;

  // Generate/propagate adder for one half; returns {carry_out, sum}.
  function automatic logic [H:0] cla_add(input logic [H-1:0] a,
                                         input logic [H-1:0] b,
                                         input logic         cin);
    logic [H-1:0] g;
    logic [H-1:0] p;
    logic [H:0]   c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    for (int i = 0; i < H; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[H], p ^ c[H-1:0]};
  endfunction

  logic         vld_p1_q, vld_p1_d;
  logic [H-1:0] lo_diff_p1_q, lo_diff_p1_d;
  logic         carry_p1_q, carry_p1_d;
  logic [H-1:0] a_hi_p1_q, a_hi_p1_d;
  logic [H-1:0] bn_hi_p1_q, bn_hi_p1_d;

  logic            vld_p2_q, vld_p2_d;
  logic [SIZE-1:0] diff_p2_q, diff_p2_d;
  logic            borrow_p2_q, borrow_p2_d;
`ifdef LA_SUB_OVF_EN
  logic            ovf_p2_q, ovf_p2_d;
  logic            a_msb, b_msb;
`endif

  logic         s2_load;
  logic         in_fire;
  logic [H:0]   lo_sum;
  logic [H:0]   hi_sum;

  always_comb begin
    s2_load  = vld_p1_q && (!vld_p2_q || out_ready);
    in_ready = !rst && (!vld_p1_q || s2_load);
    in_fire  = in_valid && in_ready;
  end

  // Stage 0 -> 1: lower half resolved, upper operands captured with B pre-inverted.
  always_comb begin
    lo_sum       = cla_add(minuend[H-1:0], ~subtrahend[H-1:0], ~borrow_in);
    vld_p1_d     = in_fire ? 1'b1 : (s2_load ? 1'b0 : vld_p1_q);
    lo_diff_p1_d = in_fire ? lo_sum[H-1:0] : lo_diff_p1_q;
    carry_p1_d   = in_fire ? lo_sum[H] : carry_p1_q;
    a_hi_p1_d    = in_fire ? minuend[SIZE-1:H] : a_hi_p1_q;
    bn_hi_p1_d   = in_fire ? ~subtrahend[SIZE-1:H] : bn_hi_p1_q;
  end

  // Stage 1 -> 2: upper half from the registered lower carry.
  always_comb begin
    hi_sum      = cla_add(a_hi_p1_q, bn_hi_p1_q, carry_p1_q);
    vld_p2_d    = s2_load ? 1'b1 : (out_ready ? 1'b0 : vld_p2_q);
    diff_p2_d   = s2_load ? {hi_sum[H-1:0], lo_diff_p1_q} : diff_p2_q;
    borrow_p2_d = s2_load ? ~hi_sum[H] : borrow_p2_q;
`ifdef LA_SUB_OVF_EN
    a_msb    = a_hi_p1_q[H-1];
    b_msb    = ~bn_hi_p1_q[H-1];
    ovf_p2_d = s2_load ? ((a_msb ^ b_msb) & (hi_sum[H-1] ^ a_msb)) : ovf_p2_q;
`endif
  end

  always_ff @(posedge clk) begin
    lo_diff_p1_q <= lo_diff_p1_d;
    carry_p1_q   <= carry_p1_d;
    a_hi_p1_q    <= a_hi_p1_d;
    bn_hi_p1_q   <= bn_hi_p1_d;
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      diff_p2_q   <= '0;
      borrow_p2_q <= 1'b0;
`ifdef LA_SUB_OVF_EN
      ovf_p2_q    <= 1'b0;
`endif
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      diff_p2_q   <= diff_p2_d;
      borrow_p2_q <= borrow_p2_d;
`ifdef LA_SUB_OVF_EN
      ovf_p2_q    <= ovf_p2_d;
`endif
    end
  end

  assign out_valid  = vld_p2_q;
  assign diff       = diff_p2_q;
  assign borrow_out = borrow_p2_q;
`ifdef LA_SUB_OVF_EN
  assign overflow   = ovf_p2_q;
`endif

endmodule

// File: tb/tb_lookahead_sub_pipe.sv
// Directed bench for lookahead_sub_pipe (SIZE=8): vector table plus backpressure and reset sequences.
module tb_lookahead_sub_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] minuend;
  logic [7:0] subtrahend;
  logic       borrow_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef LA_SUB_OVF_EN
  logic       overflow;
`endif

  lookahead_sub_pipe #(.SIZE(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .minuend(minuend),
    .subtrahend(subtrahend),
    .borrow_in(borrow_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
    .borrow_out(borrow_out)
`ifdef LA_SUB_OVF_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
    in_valid   = v;
    minuend    = a;
    subtrahend = b;
    borrow_in  = bin;
  endtask

  initial begin
    vecs[0]  = '{8'h02, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[1]  = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{8'h16, 8'h17, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[6]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_diff", {24'b0, diff}, 32'd0);
    check("reset_borrow", {31'b0, borrow_out}, 32'd0);
`ifdef LA_SUB_OVF_EN
    check("reset_ovf", {31'b0, overflow}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

    // Table: one operation at a time, output expected exactly one edge after stage 1 loads.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin);
      #1;
      check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      check($sformatf("v%0d_lat_not_early", i), {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("v%0d_diff", i), {24'b0, diff}, {24'b0, vecs[i].d});
      check($sformatf("v%0d_borrow", i), {31'b0, borrow_out}, {31'b0, vecs[i].bo});
`ifdef LA_SUB_OVF_EN
      check($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
`endif
      @(negedge clk);
      check($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'd0);
    end

    // Backpressure: two accepted, third stalls, results drain in order.
    out_ready = 1'b0;
    drive(1'b1, 8'd6, 8'd2, 1'b0);
    #1;
    check("bp_accept1", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    drive(1'b1, 8'd1, 8'd7, 1'b0);
    #1;
    check("bp_accept2", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    drive(1'b1, 8'd9, 8'd3, 1'b0);
    #1;
    check("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold_valid%0d", k), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp_hold_diff%0d", k), {24'b0, diff}, 32'h04);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_r0_diff", {24'b0, diff}, 32'h04);
    check("bp_r0_borrow", {31'b0, borrow_out}, 32'd0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("bp_r1_valid", {31'b0, out_valid}, 32'd1);
    check("bp_r1_diff", {24'b0, diff}, 32'hFA);
    check("bp_r1_borrow", {31'b0, borrow_out}, 32'd1);
    @(negedge clk);
    check("bp_r2_valid", {31'b0, out_valid}, 32'd1);
    check("bp_r2_diff", {24'b0, diff}, 32'h06);
    check("bp_r2_borrow", {31'b0, borrow_out}, 32'd0);
    @(negedge clk);
    check("bp_empty", {31'b0, out_valid}, 32'd0);

    // Reset with both stages occupied discards everything.
    out_ready = 1'b0;
    drive(1'b1, 8'h33, 8'h11, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h44, 8'h11, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("rst_pre_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_after_in_ready", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_no_stale%0d", k), {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end

    // Full throughput: back-to-back operations with out_ready high.
    drive(1'b1, 8'h20, 8'h01, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h20, 8'h02, 1'b0);
    #1;
    check("tp_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("tp_r0", {23'b0, out_valid, diff}, {23'b0, 1'b1, 8'h1F});
    @(negedge clk);
    check("tp_r1", {23'b0, out_valid, diff}, {23'b0, 1'b1, 8'h1E});
    @(negedge clk);
    check("tp_done", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
